dmem_responder: RTL and testbench

Memory-side responder for the data-memory requests issued by the pipeline's MEM stage. It accepts one load/store request at a time over a valid/ready handshake and performs it on an internal synchronous doubleword array after a programmable latency. It returns a response (read data or error) over a second valid/ready handshake. It replaces the DPI-backed data memory for standalone simulation and for future bus integration.

---
 rtl/dmem_responder.sv | 109 ++++++++++
 tb/tb_dmem_responder.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder: one load/store at a time, response LATENCY cycles after accept.
// Requests are refused while an access or response is outstanding; the response is held until taken.
module dmem_responder #(
   parameter int unsigned DEPTH_LOG2 = 10,
   parameter logic [63:0] BASE_ADDR  = 64'h0000_0000_8000_0000,
   parameter int unsigned LATENCY    = 2
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_req_valid,
   output logic        o_req_ready,
   input  logic        i_req_wen,
   input  logic [63:0] i_req_addr,
   input  logic [7:0]  i_req_wstrb,
   input  logic [63:0] i_req_wdata,
   output logic        o_rsp_valid,
   input  logic        i_rsp_ready,
   output logic [63:0] o_rsp_rdata,
   output logic        o_rsp_err
);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

   typedef struct packed {
      logic        wen;
      logic [63:0] addr;
      logic [7:0]  wstrb;
      logic [63:0] wdata;
   } req_t;

   localparam logic [63:0] SPAN     = 64'd8 << DEPTH_LOG2;
   localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

   state_t              r_state;
   req_t                r_req;
   logic [3:0]          r_cnt;
   logic                r_rsp_valid;
   logic [63:0]         r_rsp_rdata;
   logic                r_rsp_err;
   logic [63:0]         r_mem [0:(1 << DEPTH_LOG2) - 1];

   logic [63:0]         w_off;
   logic                w_in_range;
   logic [DEPTH_LOG2-1:0] w_idx;
   logic                w_access;
   logic                w_accept;

   assign o_req_ready = (r_state == S_IDLE) && !i_rst;
   assign w_accept    = i_req_valid && o_req_ready;
   assign w_off       = r_req.addr - BASE_ADDR;
   // The explicit lower-bound test keeps addresses below BASE_ADDR out even if the offset wraps.
   assign w_in_range  = (r_req.addr >= BASE_ADDR) && (w_off < SPAN);
   assign w_idx       = w_off[DEPTH_LOG2+2:3];
   assign w_access    = (r_state == S_WAIT) && (r_cnt == 4'd0);

   assign o_rsp_valid = r_rsp_valid;
   assign o_rsp_rdata = r_rsp_rdata;
   assign o_rsp_err   = r_rsp_err;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state     <= S_IDLE;
         r_cnt       <= 4'd0;
         r_rsp_valid <= 1'b0;
         r_rsp_rdata <= 64'd0;
         r_rsp_err   <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_req   <= '{wen: i_req_wen, addr: i_req_addr,
                               wstrb: i_req_wstrb, wdata: i_req_wdata};
                  r_cnt   <= CNT_INIT;
                  r_state <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (r_cnt != 4'd0) begin
                  r_cnt <= r_cnt - 4'd1;
               end else begin
                  r_rsp_err   <= !w_in_range;
                  r_rsp_rdata <= (w_in_range && !r_req.wen) ? r_mem[w_idx] : 64'd0;
                  r_rsp_valid <= 1'b1;
                  r_state     <= S_RESP;
               end
            end
            S_RESP: begin
               if (i_rsp_ready) begin
                  r_rsp_valid <= 1'b0;
                  r_state     <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Array is never reset; a store caught by reset before its access edge is simply dropped.
   always_ff @(posedge i_clk) begin
      if (!i_rst && w_access && w_in_range && r_req.wen) begin
         for (int i = 0; i < 8; i++) begin
            if (r_req.wstrb[i]) begin
               r_mem[w_idx][8*i +: 8] <= r_req.wdata[8*i +: 8];
            end
         end
      end
   end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: four instances at LATENCY 2, 3, 1 and 15 share the request bus.
module tb_dmem_responder;

   localparam int NI = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_wen;
   logic [63:0] req_addr;
   logic [7:0]  req_wstrb;
   logic [63:0] req_wdata;
   logic        req_valid [NI];
   logic        rsp_ready [NI];
   logic        req_ready [NI];
   logic        rsp_valid [NI];
   logic [63:0] rsp_rdata [NI];
   logic        rsp_err   [NI];

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   function automatic int lat_of(input int g);
      case (g)
         0:       return 2;
         1:       return 3;
         2:       return 1;
         default: return 15;
      endcase
   endfunction

   for (genvar g = 0; g < NI; g++) begin : g_dut
      dmem_responder #(
         .DEPTH_LOG2(10),
         .BASE_ADDR (64'h0000_0000_8000_0000),
         .LATENCY   (lat_of(g))
      ) u_dut (
         .i_clk      (clk),
         .i_rst      (rst),
         .i_req_valid(req_valid[g]),
         .o_req_ready(req_ready[g]),
         .i_req_wen  (req_wen),
         .i_req_addr (req_addr),
         .i_req_wstrb(req_wstrb),
         .i_req_wdata(req_wdata),
         .o_rsp_valid(rsp_valid[g]),
         .i_rsp_ready(rsp_ready[g]),
         .o_rsp_rdata(rsp_rdata[g]),
         .o_rsp_err  (rsp_err[g])
      );
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   // One complete transaction; lat counts edges from the accept edge to rsp_valid rising.
   task automatic xact(input int k, input logic wen, input logic [63:0] addr,
                       input logic [7:0] wstrb, input logic [63:0] wdata,
                       output int lat, output logic [63:0] rdata, output logic err);
      int n;
      bit seen;
      @(posedge clk); #1;
      req_wen   = wen;
      req_addr  = addr;
      req_wstrb = wstrb;
      req_wdata = wdata;
      req_valid[k] = 1'b1;
      n = 0;
      while (!req_ready[k] && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      @(posedge clk); #1;
      req_valid[k] = 1'b0;
      lat  = 0;
      seen = 1'b0;
      while (!seen && lat < 40) begin
         @(posedge clk); #1;
         lat++;
         seen = rsp_valid[k];
      end
      check("rsp_seen", 64'(seen), 64'd1);
      rdata = rsp_rdata[k];
      err   = rsp_err[k];
      rsp_ready[k] = 1'b1;
      @(posedge clk); #1;
      rsp_ready[k] = 1'b0;
   endtask

   task automatic do_st(input string tag, input int k, input logic [63:0] addr,
                        input logic [7:0] wstrb, input logic [63:0] wdata, input logic exp_err);
      int lat;
      logic [63:0] rd;
      logic er;
      xact(k, 1'b1, addr, wstrb, wdata, lat, rd, er);
      check({tag, "_lat"},   64'(lat), 64'(lat_of(k)));
      check({tag, "_err"},   64'(er),  64'(exp_err));
      check({tag, "_rdata"}, rd,       64'd0);
   endtask

   // Loads drive junk on wstrb/wdata, which must have no effect.
   task automatic do_ld(input string tag, input int k, input logic [63:0] addr,
                        input logic [63:0] exp_data, input logic exp_err);
      int lat;
      logic [63:0] rd;
      logic er;
      xact(k, 1'b0, addr, 8'h5A, 64'hDEAD_BEEF_0BAD_F00D, lat, rd, er);
      check({tag, "_lat"},   64'(lat), 64'(lat_of(k)));
      check({tag, "_err"},   64'(er),  64'(exp_err));
      check({tag, "_rdata"}, rd,       exp_data);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int a0, a1, v0;
      bit seen;

      rst       = 1'b1;
      req_wen   = 1'b0;
      req_addr  = 64'd0;
      req_wstrb = 8'd0;
      req_wdata = 64'd0;
      for (int k = 0; k < NI; k++) begin
         req_valid[k] = 1'b0;
         rsp_ready[k] = 1'b0;
      end
      repeat (2) @(posedge clk);
      #1;
      for (int k = 0; k < NI; k++) begin
         check("rst_rsp_valid", 64'(rsp_valid[k]), 64'd0);
         check("rst_rsp_rdata", rsp_rdata[k],      64'd0);
         check("rst_rsp_err",   64'(rsp_err[k]),   64'd0);
         check("rst_req_ready", 64'(req_ready[k]), 64'd0);
      end
      rst = 1'b0;
      @(posedge clk); #1;
      check("idle_req_ready", 64'(req_ready[0]), 64'd1);

      // Basic store/load, partial strobe, empty strobe, ignored low address bits.
      do_st("st_full",  0, 64'h8000_0010, 8'hFF, 64'h1122_3344_5566_7788, 1'b0);
      do_ld("ld_full",  0, 64'h8000_0010, 64'h1122_3344_5566_7788, 1'b0);
      do_st("st_part",  0, 64'h8000_0010, 8'h0F, 64'hAAAA_AAAA_AAAA_AAAA, 1'b0);
      do_ld("ld_part",  0, 64'h8000_0010, 64'h1122_3344_AAAA_AAAA, 1'b0);
      do_st("st_nostb", 0, 64'h8000_0010, 8'h00, 64'h5555_5555_5555_5555, 1'b0);
      do_ld("ld_low",   0, 64'h8000_0013, 64'h1122_3344_AAAA_AAAA, 1'b0);

      // Out-of-range accesses; aliases of entry 0 and the last entry must stay untouched.
      do_st("st_e0",    0, 64'h8000_0000, 8'hFF, 64'hCAFE_F00D_DEAD_BEEF, 1'b0);
      do_st("st_elast", 0, 64'h8000_1FF8, 8'hFF, 64'h0F0E_0D0C_0B0A_0908, 1'b0);
      do_ld("ld_below", 0, 64'h7FFF_FFF8, 64'd0, 1'b1);
      do_ld("ld_above", 0, 64'h8000_2000, 64'd0, 1'b1);
      do_st("st_above", 0, 64'h8000_2000, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
      do_st("st_below", 0, 64'h7FFF_FFF8, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
      do_ld("ld_e0",    0, 64'h8000_0000, 64'hCAFE_F00D_DEAD_BEEF, 1'b0);
      do_ld("ld_elast", 0, 64'h8000_1FF8, 64'h0F0E_0D0C_0B0A_0908, 1'b0);
      do_ld("ld_e2",    0, 64'h8000_0010, 64'h1122_3344_AAAA_AAAA, 1'b0);

      // Backpressure: response held five cycles while a second request waits.
      @(posedge clk); #1;
      req_wen   = 1'b0;
      req_addr  = 64'h8000_0010;
      req_valid[0] = 1'b1;
      check("bp_rdy_idle", 64'(req_ready[0]), 64'd1);
      @(posedge clk); #1;
      req_addr = 64'h8000_0000;
      n = 0;
      while (!rsp_valid[0] && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      for (int i = 0; i < 5; i++) begin
         check("bp_hold_valid", 64'(rsp_valid[0]), 64'd1);
         check("bp_hold_rdata", rsp_rdata[0],      64'h1122_3344_AAAA_AAAA);
         check("bp_hold_ready", 64'(req_ready[0]), 64'd0);
         @(posedge clk); #1;
      end
      rsp_ready[0] = 1'b1;
      @(posedge clk); #1;
      rsp_ready[0] = 1'b0;
      check("bp_valid_clr", 64'(rsp_valid[0]), 64'd0);
      check("bp_ready_back", 64'(req_ready[0]), 64'd1);
      @(posedge clk); #1;
      req_valid[0] = 1'b0;
      check("bp_accepted", 64'(req_ready[0]), 64'd0);
      n = 0;
      while (!rsp_valid[0] && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      check("bp2_lat",   64'(n), 64'd2);
      check("bp2_rdata", rsp_rdata[0], 64'hCAFE_F00D_DEAD_BEEF);
      rsp_ready[0] = 1'b1;
      @(posedge clk); #1;
      rsp_ready[0] = 1'b0;

      // Reset while a store sits in WAIT (LATENCY=3): store lost, no response.
      do_st("rs_init", 1, 64'h8000_0000, 8'hFF, 64'h0123_4567_89AB_CDEF, 1'b0);
      @(posedge clk); #1;
      req_wen   = 1'b1;
      req_addr  = 64'h8000_0000;
      req_wstrb = 8'hFF;
      req_wdata = 64'hFFFF_FFFF_FFFF_FFFF;
      req_valid[1] = 1'b1;
      check("rs_rdy", 64'(req_ready[1]), 64'd1);
      @(posedge clk); #1;
      req_valid[1] = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      check("rs_rdy_in_rst", 64'(req_ready[1]), 64'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (rsp_valid[1]) seen = 1'b1;
         @(posedge clk); #1;
      end
      check("rs_no_rsp", 64'(seen), 64'd0);
      do_ld("rs_ld", 1, 64'h8000_0000, 64'h0123_4567_89AB_CDEF, 1'b0);

      // LATENCY=1, streaming with rsp_ready tied high; one IDLE cycle follows each handshake.
      do_st("l1_st", 2, 64'h8000_0100, 8'hFF, 64'h0000_1111_2222_3333, 1'b0);
      do_ld("l1_ld", 2, 64'h8000_0100, 64'h0000_1111_2222_3333, 1'b0);
      @(posedge clk); #1;
      req_wen   = 1'b0;
      req_addr  = 64'h8000_0100;
      rsp_ready[2] = 1'b1;
      req_valid[2] = 1'b1;
      a0 = -1;
      a1 = -1;
      v0 = -1;
      for (int c = 0; c < 12; c++) begin
         if (req_ready[2]) begin
            if (a0 < 0) a0 = c;
            else if (a1 < 0) a1 = c;
         end
         if (rsp_valid[2] && v0 < 0) v0 = c;
         @(posedge clk); #1;
      end
      req_valid[2] = 1'b0;
      check("b2b_lat",    64'(v0 - a0 - 1), 64'd1);
      check("b2b_period", 64'(a1 - a0),     64'd3);
      repeat (5) @(posedge clk);
      #1;
      rsp_ready[2] = 1'b0;

      // LATENCY=15.
      do_st("l15_st", 3, 64'h8000_0008, 8'hF0, 64'h7766_5544_3322_1100, 1'b0);
      do_st("l15_st2", 3, 64'h8000_0008, 8'h0F, 64'h0000_0000_0A0B_0C0D, 1'b0);
      do_ld("l15_ld", 3, 64'h8000_0008, 64'h7766_5544_0A0B_0C0D, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
